mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage that sits directly downstream of the ALU in the pipelined processor.
- Takes the EX-stage result: the ALU result serves as the load/store address, or passes through as writeback data for non-memory ops.
- Runs byte/half/word loads and stores over a req/ready data-memory handshake and stalls upstream while an access is in flight.
- Produces registered MEM/WB outputs for the writeback stage.

Parameters:
- XLEN, 32, datapath and address width (only 32 is supported)
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX stage presents a valid instruction
- ex_alu_res  input  XLEN  ALU result (memory address for ld/st)
- ex_store_data  input  XLEN  store data (rs2)
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_size  input  2  00 byte, 01 half, 10/11 word
- ex_unsigned  input  1  zero-extend load when 1, sign-extend when 0
- ex_rd  input  REG_ADDR_W  destination register
- ex_reg_write  input  1  instruction writes rd
- mem_stall  output  1  upstream must hold ex_* stable
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_addr  output  XLEN  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  output  XLEN  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  memory completes request this cycle
- dmem_rdata  input  XLEN  read word, valid when dmem_ready=1
- wb_valid  output  1  one-cycle pulse per retired instruction
- wb_data  output  XLEN  writeback data
- wb_rd  output  REG_ADDR_W  writeback register
- wb_reg_write  output  1  register-file write enable
- misalign  output  1  pulses with wb_valid for a misaligned access

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) and reset mid-access:
  - state <= IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data, wb_rd, wb_reg_write and misalign all <= 0.
  - An in-flight access is abandoned; dmem_req is low from the cycle after the reset edge.
- FSM has two states, IDLE and ACCESS. mem_stall = (state==ACCESS), combinational. ex_* are sampled only in IDLE.
- IDLE, ex_valid=0: wb_valid<=0; wb_data, wb_rd and wb_reg_write hold.
- IDLE, ex_valid=1, no memory op: next cycle wb_valid=1, wb_data=ex_alu_res, wb_rd=ex_rd, wb_reg_write=ex_reg_write (latency 1).
- Read and write both set: the read takes priority and the write is ignored.
- Misalignment:
  - Half is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]!=00.
  - A misaligned access issues no request. Next cycle: wb_valid=1, misalign=1, wb_reg_write=0, wb_rd=ex_rd, wb_data=ex_alu_res. Stay in IDLE.
- Aligned memory op in IDLE:
  - Register dmem_req=1, dmem_we=ex_mem_write&~ex_mem_read, dmem_addr, dmem_be and dmem_wdata.
  - Capture rd, reg_write, size, unsigned and addr[1:0]. Go to ACCESS. wb_valid<=0.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
  - Driven identically for reads.
- Store data: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
- ACCESS:
  - All dmem_* outputs held stable until dmem_ready.
  - When dmem_ready=1: dmem_req<=0, state<=IDLE, wb_valid<=1, misalign<=0.
  - Load: wb_data = lane selected by the captured addr[1:0]/size, sign- or zero-extended; wb_reg_write = captured reg_write.
  - Store: wb_reg_write=0, wb_data=0.
- Timing: an instruction accepted at cycle T with dmem_ready at T+k (k>=1) gives wb_valid at T+k+1. mem_stall is high T+1..T+k. The held next instruction is accepted at T+k+1, so back-to-back ops incur no bubble beyond the handshake.
- dmem_ready while in IDLE is ignored.
- wb_valid is never high on two consecutive cycles for the same instruction.

Test Plan:
- ALU pass-through: ex_valid=1, no mem op, alu_res=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, wb_reg_write=1, dmem_req never asserted.
- Signed byte load: addr=0x103, size=00, unsigned=0, ready after 3 cycles, rdata=0x80FF_0000 -> dmem_addr=0x100, be=1000, mem_stall high 3 cycles, wb_data=0xFFFF_FF80; same with unsigned=1 -> 0x0000_0080.
- Half store: addr=0x22, sd=0xAAAA_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, wb_valid with wb_reg_write=0 the cycle after ready.
- Misaligned word load at addr=0x41 -> no dmem_req, next cycle wb_valid=1, misalign=1, wb_reg_write=0.
- Back-to-back: word load then ALU op with ready at the first ACCESS cycle -> wb pulses on consecutive cycles; the held ALU op retires exactly once.
- rst asserted during ACCESS with ready low -> next cycle dmem_req=0, mem_stall=0, all wb outputs 0; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
//   master : memory stage  drives dmem_req/we/addr/wdata/be, receives dmem_ready/rdata
//   slave  : data memory   receives the request, drives dmem_ready/rdata
interface mem_access_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage. Takes the EX result, performs byte/half/word loads and stores over
// a req/ready data-memory handshake (stalling upstream while in flight) and produces
// registered MEM/WB outputs.
//   clk, rst      : clock, synchronous active-high reset
//   ex_*          : instruction from EX, sampled only while idle
//   mem_stall     : upstream must hold ex_* stable
//   dmem          : data-memory bus (master side)
//   wb_*/misalign : registered writeback outputs, wb_valid pulses once per instruction
module mem_access_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       ex_alu_res,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_size,
    input  logic                  ex_unsigned,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    output logic                  mem_stall,
    mem_access_stage_if.master    dmem,
    output logic                  wb_valid,
    output logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write,
    output logic                  misalign
);
    localparam logic StIdle   = 1'b0;
    localparam logic StAccess = 1'b1;

    logic                  state_q, state_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [XLEN-1:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, misalign_q, misalign_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    // Attributes of the access in flight
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  rw_q, rw_d, uns_q, uns_d, is_load_q, is_load_d;
    logic [1:0]            size_q, size_d, off_q, off_d;

    logic            mem_op, bad_align;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign mem_op    = ex_mem_read | ex_mem_write;
    assign bad_align = (ex_size == 2'b01) ? ex_alu_res[0] :
                       (ex_size[1]        ? (ex_alu_res[1:0] != 2'b00) : 1'b0);

    // Lane extraction from the returned word, using the captured offset/size
    always_comb begin
        unique case (off_q)
            2'd0:    ld_byte = dmem.dmem_rdata[7:0];
            2'd1:    ld_byte = dmem.dmem_rdata[15:8];
            2'd2:    ld_byte = dmem.dmem_rdata[23:16];
            default: ld_byte = dmem.dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        unique case (size_q)
            2'b00:   ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        misalign_d = 1'b0;
        rd_d       = rd_q;
        rw_d       = rw_q;
        uns_d      = uns_q;
        is_load_d  = is_load_q;
        size_d     = size_q;
        off_d      = off_q;

        if (state_q == StIdle) begin
            if (ex_valid) begin
                if (!mem_op || bad_align) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_alu_res;
                    wb_rd_d    = ex_rd;
                    wb_rw_d    = mem_op ? 1'b0 : ex_reg_write;
                    misalign_d = mem_op;
                end else begin
                    state_d   = StAccess;
                    req_d     = 1'b1;
                    // Read wins when both read and write are set
                    we_d      = ex_mem_write & ~ex_mem_read;
                    addr_d    = {ex_alu_res[XLEN-1:2], 2'b00};
                    unique case (ex_size)
                        2'b00: begin
                            be_d    = 4'b0001 << ex_alu_res[1:0];
                            wdata_d = {4{ex_store_data[7:0]}};
                        end
                        2'b01: begin
                            be_d    = ex_alu_res[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{ex_store_data[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = ex_store_data;
                        end
                    endcase
                    rd_d      = ex_rd;
                    rw_d      = ex_reg_write;
                    uns_d     = ex_unsigned;
                    is_load_d = ex_mem_read;
                    size_d    = ex_size;
                    off_d     = ex_alu_res[1:0];
                end
            end
        end else if (dmem.dmem_ready) begin
            state_d    = StIdle;
            req_d      = 1'b0;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = is_load_q ? ld_data : '0;
            wb_rw_d    = is_load_q & rw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            misalign_q <= 1'b0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            uns_q      <= 1'b0;
            is_load_q  <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            misalign_q <= misalign_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            uns_q      <= uns_d;
            is_load_q  <= is_load_d;
            size_q     <= size_d;
            off_q      <= off_d;
        end
    end

    assign mem_stall       = (state_q == StAccess);
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign wb_valid        = wb_valid_q;
    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_reg_write    = wb_rw_q;
    assign misalign        = misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
    logic [31:0] ex_alu_res, ex_store_data;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rd;
    logic        mem_stall, wb_valid, wb_reg_write, misalign;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int total = 0;
    int bad   = 0;

    mem_access_stage_if #(.XLEN(32)) dmem ();

    mem_access_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_alu_res   (ex_alu_res),
        .ex_store_data(ex_store_data),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .mem_stall    (mem_stall),
        .dmem         (dmem.master),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] a, input logic [31:0] sd,
                          input logic rd_op, input logic wr_op, input logic [1:0] sz,
                          input logic uns, input logic [4:0] rd, input logic rw);
        ex_valid      = v;
        ex_alu_res    = a;
        ex_store_data = sd;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_size       = sz;
        ex_unsigned   = uns;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    initial begin
        rst = 1'b1;
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);

        // ALU pass-through
        set_ex(1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 1'b1);
        tick();
        chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("alu_wb_data", wb_data, 32'h0000_1234);
        chk("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
        chk("alu_wb_rw", {31'b0, wb_reg_write}, 32'd1);
        chk("alu_req", {31'b0, dmem.dmem_req}, 32'd0);
        ex_valid = 1'b0;
        tick();
        chk("alu_pulse_end", {31'b0, wb_valid}, 32'd0);
        chk("alu_hold_data", wb_data, 32'h0000_1234);

        // Byte load at 0x103, signed then unsigned, ready on the third ACCESS cycle
        for (int u = 0; u < 2; u++) begin
            set_ex(1'b1, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, u[0], 5'd7, 1'b1);
            tick();
            chk("lb_addr", dmem.dmem_addr, 32'h0000_0100);
            chk("lb_be", {28'b0, dmem.dmem_be}, 32'b1000);
            chk("lb_we", {31'b0, dmem.dmem_we}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                chk("lb_stall", {31'b0, mem_stall}, 32'd1);
                chk("lb_req", {31'b0, dmem.dmem_req}, 32'd1);
                chk("lb_no_wb", {31'b0, wb_valid}, 32'd0);
                if (i == 2) begin
                    dmem.dmem_ready = 1'b1;
                    dmem.dmem_rdata = 32'h80FF_0000;
                end
                tick();
            end
            dmem.dmem_ready = 1'b0;
            ex_valid = 1'b0;
            chk("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
            chk("lb_wb_data", wb_data, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_wb_rd", {27'b0, wb_rd}, 32'd7);
            chk("lb_wb_rw", {31'b0, wb_reg_write}, 32'd1);
            chk("lb_stall_end", {31'b0, mem_stall}, 32'd0);
            chk("lb_req_end", {31'b0, dmem.dmem_req}, 32'd0);
            tick();
            chk("lb_pulse_end", {31'b0, wb_valid}, 32'd0);
        end

        // Half store at 0x22
        set_ex(1'b1, 32'h0000_0022, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd4, 1'b1);
        tick();
        chk("sh_we", {31'b0, dmem.dmem_we}, 32'd1);
        chk("sh_be", {28'b0, dmem.dmem_be}, 32'b1100);
        chk("sh_wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem.dmem_addr, 32'h0000_0020);
        ex_valid = 1'b0;
        dmem.dmem_ready = 1'b1;
        tick();
        dmem.dmem_ready = 1'b0;
        chk("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sh_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("sh_wb_data", wb_data, 32'd0);

        // Misaligned word load at 0x41
        set_ex(1'b1, 32'h0000_0041, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd6, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("mis_req", {31'b0, dmem.dmem_req}, 32'd0);
        chk("mis_stall", {31'b0, mem_stall}, 32'd0);
        chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("mis_wb_data", wb_data, 32'h0000_0041);
        chk("mis_wb_rd", {27'b0, wb_rd}, 32'd6);
        tick();
        chk("mis_flag_end", {31'b0, misalign}, 32'd0);
        chk("mis_req_after", {31'b0, dmem.dmem_req}, 32'd0);

        // Back-to-back: word load, then an ALU op held during the access
        set_ex(1'b1, 32'h0000_0080, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd3, 1'b1);
        tick();
        chk("b2b_req", {31'b0, dmem.dmem_req}, 32'd1);
        chk("b2b_be", {28'b0, dmem.dmem_be}, 32'b1111);
        set_ex(1'b1, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1);
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem.dmem_ready = 1'b0;
        chk("b2b_ld_valid", {31'b0, wb_valid}, 32'd1);
        chk("b2b_ld_data", wb_data, 32'hDEAD_BEEF);
        chk("b2b_ld_rd", {27'b0, wb_rd}, 32'd3);
        tick();
        ex_valid = 1'b0;
        chk("b2b_alu_valid", {31'b0, wb_valid}, 32'd1);
        chk("b2b_alu_data", wb_data, 32'h0000_0055);
        chk("b2b_alu_rd", {27'b0, wb_rd}, 32'd9);
        chk("b2b_alu_req", {31'b0, dmem.dmem_req}, 32'd0);
        tick();
        chk("b2b_once", {31'b0, wb_valid}, 32'd0);

        // Reset during an access with ready low
        set_ex(1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd2, 1'b1);
        tick();
        chk("rma_req", {31'b0, dmem.dmem_req}, 32'd1);
        rst = 1'b1;
        ex_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rma_req_off", {31'b0, dmem.dmem_req}, 32'd0);
        chk("rma_stall", {31'b0, mem_stall}, 32'd0);
        chk("rma_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rma_wb_data", wb_data, 32'd0);
        chk("rma_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rma_wb_rw", {31'b0, wb_reg_write}, 32'd0);

        // Signed half load from upper lane after reset
        set_ex(1'b1, 32'h0000_0012, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd8, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("lh_be", {28'b0, dmem.dmem_be}, 32'b1100);
        chk("lh_addr", dmem.dmem_addr, 32'h0000_0010);
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'h8001_0000;
        tick();
        dmem.dmem_ready = 1'b0;
        chk("lh_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lh_wb_data", wb_data, 32'hFFFF_8001);
        chk("lh_wb_rd", {27'b0, wb_rd}, 32'd8);

        // Byte store at offset 1
        set_ex(1'b1, 32'h0000_0001, 32'h1234_56A5, 1'b0, 1'b1, 2'b00, 1'b0, 5'd1, 1'b0);
        tick();
        ex_valid = 1'b0;
        chk("sb_be", {28'b0, dmem.dmem_be}, 32'b0010);
        chk("sb_wdata", dmem.dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", dmem.dmem_addr, 32'h0000_0000);
        dmem.dmem_ready = 1'b1;
        tick();
        dmem.dmem_ready = 1'b0;
        chk("sb_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sb_wb_rw", {31'b0, wb_reg_write}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
